// File: rtl/gpio_trig_pkg.sv
// Shared types and defaults for the GPIO trigger pulse generator.
// State encoding, default widths and the synchronizer depth floor.
package gpio_trig_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned IDX_W_DEF = 16;
  localparam int unsigned SYNC_MIN  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_HIGH,
    ST_LOW
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// o_rise is a one-cycle strobe aligned to the last sync stage.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/gpio_trigger_pulse_gen.sv
// Delayed, programmable pulse-train generator driving a GPIO pin.
// Config is shadowed at the start edge so a running train is stable.
module gpio_trigger_pulse_gen
  import gpio_trig_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_W_DEF,
  parameter int unsigned IDX_WIDTH   = IDX_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 soft_trig,
  input  logic                 ext_trig,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] width,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [IDX_WIDTH-1:0] count,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_WIDTH-1:0] pulse_index
);

  localparam int unsigned SYNC_N =
    (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam int unsigned PW = CNT_WIDTH + 1;

  state_t r_state;
  state_t w_next;

  logic                 r_soft_q;
  logic                 r_pulse;
  logic [CNT_WIDTH-1:0] r_delay;
  logic [CNT_WIDTH-1:0] r_wlim;
  logic [CNT_WIDTH-1:0] r_dcnt;
  logic [PW-1:0]        r_plim;
  logic [PW-1:0]        r_ph;
  logic [IDX_WIDTH-1:0] r_count;
  logic [IDX_WIDTH-1:0] r_idx;

  logic                 w_ext_rise;
  logic                 w_soft_rise;
  logic                 w_start;
  logic                 w_last;
  logic                 w_done;
  logic [CNT_WIDTH-1:0] w_weff;
  logic [PW-1:0]        w_wp1;
  logic [PW-1:0]        w_per;
  logic [PW-1:0]        w_peff;

  sync_edge_detect #(
    .STAGES (SYNC_N)
  ) u_ext_sync (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_d     (ext_trig),
    .o_rise  (w_ext_rise)
  );

  assign w_soft_rise = soft_trig & ~r_soft_q;
  assign w_start     = (w_soft_rise | w_ext_rise) & ~abort;

  // One extra bit so width = max still yields a legal period
  assign w_weff = (width == '0) ? CNT_WIDTH'(1) : width;
  assign w_wp1  = {1'b0, w_weff} + PW'(1);
  assign w_per  = {1'b0, period};
  assign w_peff = (w_per > w_wp1) ? w_per : w_wp1;

  assign w_last = (r_count != '0) && (r_idx == r_count);

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_DELAY;
      end
      ST_DELAY: begin
        if (r_dcnt == r_delay) w_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (r_ph == {1'b0, r_wlim}) w_next = ST_LOW;
      end
      ST_LOW: begin
        if (r_ph == r_plim) begin
          if (w_last) begin
            w_next = ST_IDLE;
            w_done = 1'b1;
          end else begin
            w_next = ST_HIGH;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
      w_done = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_soft_q <= 1'b0;
      r_pulse  <= 1'b0;
      r_delay  <= '0;
      r_wlim   <= '0;
      r_plim   <= '0;
      r_count  <= '0;
      r_dcnt   <= '0;
      r_ph     <= '0;
      r_idx    <= '0;
    end else begin
      r_soft_q <= soft_trig;
      r_pulse  <= (w_next == ST_HIGH);
      if ((r_state == ST_IDLE) && w_start) begin
        r_delay <= delay;
        r_wlim  <= w_weff - CNT_WIDTH'(1);
        r_plim  <= w_peff - PW'(1);
        r_count <= count;
        r_dcnt  <= '0;
        r_idx   <= '0;
      end
      if (r_state == ST_DELAY) r_dcnt <= r_dcnt + CNT_WIDTH'(1);
      if ((w_next == ST_HIGH) && (r_state != ST_HIGH)) begin
        r_ph  <= '0;
        r_idx <= r_idx + IDX_WIDTH'(1);
      end else if ((r_state == ST_HIGH) || (r_state == ST_LOW)) begin
        r_ph <= r_ph + PW'(1);
      end
    end
  end

  assign pulse_out   = r_pulse;
  assign busy        = (r_state != ST_IDLE);
  assign done        = w_done;
  assign pulse_index = r_idx;

endmodule

// File: tb/tb_gpio_trigger_pulse_gen.sv
// Bench for gpio_trigger_pulse_gen: directed and random pulse trains.
// Expected outputs come from a closed-form per-cycle train model.
module tb_gpio_trigger_pulse_gen;

  localparam int CW = 32;
  localparam int IW = 16;
  localparam longint BIG = 64'd1 << 40;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          soft_trig = 1'b0;
  logic          ext_trig = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] delay = '0;
  logic [CW-1:0] width = '0;
  logic [CW-1:0] period = '0;
  logic [IW-1:0] count = '0;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [IW-1:0] pulse_index;

  int     n_tests = 0;
  int     n_fail = 0;
  longint cyc = 0;
  bit     scramble = 0;

  bit            m_active = 0;
  longint        m_S, m_d, m_w, m_p, m_cnt;
  longint        m_end = BIG;
  longint        m_A = BIG;
  logic [IW-1:0] m_prev_idx = '0;

  gpio_trigger_pulse_gen #(
    .CNT_WIDTH   (CW),
    .IDX_WIDTH   (IW),
    .SYNC_STAGES (2)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .soft_trig   (soft_trig),
    .ext_trig    (ext_trig),
    .abort       (abort),
    .delay       (delay),
    .width       (width),
    .period      (period),
    .count       (count),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulse_index (pulse_index)
  );

  always #5 aclk = ~aclk;

  // Train occupies cycles S+1..end; pulse k rises at S+2+delay+k*p_eff
  task automatic expect_at(input longint c, output logic eb, output logic ep,
                           output logic ed, output logic [IW-1:0] ei);
    longint lim, rel, cc, r2;
    if (!m_active || c <= m_S) begin
      eb = 0; ep = 0; ed = 0; ei = m_prev_idx;
    end else begin
      lim = (m_end < m_A) ? m_end : m_A;
      rel = c - (m_S + 2 + m_d);
      eb = (c <= lim);
      ep = eb && (rel >= 0) && ((rel % m_p) < m_w);
      ed = eb && (c == m_end) && (c != m_A);
      cc = (c < lim) ? c : lim;
      r2 = cc - (m_S + 2 + m_d);
      ei = (r2 < 0) ? '0 : IW'(r2 / m_p + 1);
    end
  endtask

  task automatic cmp(input string tag, input logic [IW-1:0] obs,
                     input logic [IW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_now();
    logic eb, ep, ed;
    logic [IW-1:0] ei;
    expect_at(cyc, eb, ep, ed, ei);
    cmp("busy", IW'(busy), IW'(eb));
    cmp("pulse_out", IW'(pulse_out), IW'(ep));
    cmp("done", IW'(done), IW'(ed));
    cmp("pulse_index", pulse_index, ei);
  endtask

  task automatic adv();
    @(posedge aclk);
    cyc++;
    #1;
    if (scramble) begin
      delay  = CW'($urandom_range(0, 9));
      width  = CW'($urandom_range(0, 9));
      period = CW'($urandom_range(0, 9));
      count  = IW'($urandom_range(0, 5));
    end
  endtask

  task automatic chk();
    #2;
    check_now();
  endtask

  task automatic idle(input longint n);
    for (longint i = 0; i < n; i++) begin
      adv();
      chk();
    end
  endtask

  task automatic m_begin(input longint s);
    logic eb, ep, ed;
    logic [IW-1:0] ei;
    expect_at(s, eb, ep, ed, ei);
    m_prev_idx = ei;
    m_S   = s;
    m_d   = longint'(delay);
    m_w   = (width == '0) ? 1 : longint'(width);
    m_p   = (longint'(period) > m_w + 1) ? longint'(period) : m_w + 1;
    m_cnt = longint'(count);
    m_end = (count == '0) ? BIG : s + 2 + m_d + m_cnt * m_p - 1;
    m_A   = BIG;
    m_active = 1;
  endtask

  task automatic start_soft();
    adv();
    soft_trig = 1'b1;
    m_begin(cyc);
    chk();
    adv();
    soft_trig = 1'b0;
    chk();
  endtask

  task automatic set_cfg(input int d, input int w, input int p, input int n);
    delay = CW'(d); width = CW'(w); period = CW'(p); count = IW'(n);
  endtask

  task automatic do_abort_at(input longint a);
    idle(a - 1 - cyc);
    adv();
    abort = 1'b1;
    m_A = cyc;
    chk();
    adv();
    abort = 1'b0;
    chk();
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check_now();
    aresetn = 1'b1;
    idle(2);

    // Minimal train: one 1-cycle pulse, p_eff = 2
    set_cfg(0, 1, 1, 1);
    idle(7);
    start_soft();
    idle(m_end - cyc);
    // Back-to-back: restart in the first IDLE cycle after done
    set_cfg(5, 3, 10, 3);
    start_soft();
    idle(m_end - cyc + 3);

    // Glitch on ext_trig between sample edges must not start
    adv();
    ext_trig = 1'b1;
    #2;
    ext_trig = 1'b0;
    chk();
    idle(3);

    // External start: two extra synchronizer cycles
    adv();
    ext_trig = 1'b1;
    m_begin(cyc + 2);
    chk();
    idle(2);
    scramble = 1;
    idle(3);
    ext_trig = 1'b0;
    idle(m_end - cyc + 2);
    scramble = 0;

    // Continuous mode, stray starts while busy, abort in 7th pulse
    set_cfg(2, 2, 4, 0);
    idle(2);
    start_soft();
    idle(3);
    adv(); soft_trig = 1'b1; chk();
    adv(); soft_trig = 1'b0; ext_trig = 1'b1; chk();
    idle(4);
    ext_trig = 1'b0;
    do_abort_at(m_S + 2 + m_d + 6 * m_p + 1);
    idle(3);

    // Abort in IDLE suppresses a coincident start
    adv(); soft_trig = 1'b1; abort = 1'b1; chk();
    adv(); abort = 1'b0; chk();
    adv(); soft_trig = 1'b0; chk();
    idle(2);

    // Zero width/period clamp, config churn mid-train
    set_cfg(1, 0, 0, 2);
    idle(1);
    start_soft();
    scramble = 1;
    idle(m_end - cyc + 2);
    scramble = 0;

    // Asynchronous reset during HIGH
    set_cfg(1, 4, 6, 3);
    idle(1);
    start_soft();
    idle(m_S + 4 - cyc);
    #1;
    aresetn = 1'b0;
    #1;
    m_active = 0;
    m_prev_idx = '0;
    check_now();
    idle(2);
    adv();
    aresetn = 1'b1;
    chk();
    set_cfg(0, 1, 1, 1);
    idle(2);
    start_soft();
    idle(m_end - cyc + 2);

    // Random trains
    for (int t = 0; t < 10; t++) begin
      scramble = 0;
      set_cfg($urandom_range(0, 6), $urandom_range(0, 4),
              $urandom_range(0, 9), $urandom_range(1, 3));
      idle(2);
      start_soft();
      scramble = ($urandom_range(0, 1) == 1);
      idle(1);
      adv(); soft_trig = 1'b1; chk();
      adv(); soft_trig = 1'b0; chk();
      if (m_end >= m_S + 6 && $urandom_range(0, 3) == 0) begin
        do_abort_at(longint'($urandom_range(int'(m_S) + 6, int'(m_end))));
        idle(2);
      end else begin
        idle(m_end - cyc + 2);
      end
    end
    scramble = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
